// File: rtl/inst_bus_if_if.sv
// Core-side fetch port and instruction-bus port of inst_bus_if, bundled as one interface.
// master = fetch unit (drives bus request, returns instructions); slave = core + bus environment.
interface inst_bus_if_if;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        flush_i;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_ack_i;
  logic [31:0] bus_data_i;
  logic        err_o;

  modport master (
    input  cpu_ce_i, cpu_addr_i, flush_i, bus_ack_i, bus_data_i,
    output cpu_data_o, stallreq_o, bus_req_o, bus_addr_o, err_o
  );

  modport slave (
    output cpu_ce_i, cpu_addr_i, flush_i, bus_ack_i, bus_data_i,
    input  cpu_data_o, stallreq_o, bus_req_o, bus_addr_o, err_o
  );
endinterface

// File: rtl/inst_bus_if.sv
// Instruction fetch bridge: turns core fetches into single bus reads with a bounded ack wait.
// Latency: 3 cycles minimum per fetch (request, ack, DONE); each extra bus wait cycle adds one.
// Backpressure: stallreq_o holds pc/if_id while a fetch is outstanding; timeout returns a NOP.
module inst_bus_if #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  inst_bus_if_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state;
  logic [31:0] data_buf;
  logic [7:0]  wait_cnt;
  logic        flush_pending;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        err;

  logic        timeout;
  logic        flush_hit;
  logic        finish;

  assign timeout   = (wait_cnt == TO_LAST);
  assign flush_hit = flush_pending | bus.flush_i;
  // ack takes priority over a coinciding timeout
  assign finish    = bus.bus_ack_i | timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      bus_req       <= 1'b0;
      bus_addr      <= 32'h0;
      data_buf      <= 32'h0;
      wait_cnt      <= 8'h0;
      flush_pending <= 1'b0;
      err           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          flush_pending <= 1'b0;
          if (bus.cpu_ce_i && !bus.flush_i) begin
            bus_req  <= 1'b1;
            bus_addr <= bus.cpu_addr_i;
            wait_cnt <= 8'h0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (finish) begin
            bus_req       <= 1'b0;
            flush_pending <= 1'b0;
            if (bus.bus_ack_i) begin
              data_buf <= bus.bus_data_i;
            end else begin
              data_buf <= 32'h0;
              err      <= 1'b1;
            end
            // a flush seen at any point of the transaction discards its result
            state <= flush_hit ? S_IDLE : S_DONE;
          end else begin
            flush_pending <= flush_hit;
            if (wait_cnt != 8'hFF) begin
              wait_cnt <= wait_cnt + 8'h1;
            end
          end
        end
        S_DONE: begin
          flush_pending <= 1'b0;
          state         <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // outputs are held quiet for the whole time reset is asserted
  always_comb begin
    bus.stallreq_o = 1'b0;
    bus.cpu_data_o = 32'h0;
    if (rst) begin
      case (state)
        S_IDLE: bus.stallreq_o = bus.cpu_ce_i & ~bus.flush_i;
        S_BUSY: bus.stallreq_o = 1'b1;
        S_DONE: begin
          if (!bus.flush_i) begin
            bus.cpu_data_o = data_buf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_req_o  = bus_req;
  assign bus.bus_addr_o = bus_addr;
  assign bus.err_o      = err;

endmodule

// File: tb/tb_inst_bus_if.sv
// Scoreboard bench for inst_bus_if: three instances (default, TIMEOUT_CYC=4, TIMEOUT_CYC=3);
// the fetch task queues expected completions, a negedge monitor checks each bus completion.
module tb_inst_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, flush, ack;
  logic [31:0] addr, data_in;
  int          sel;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  inst_bus_if_if if0 ();
  inst_bus_if_if if4 ();
  inst_bus_if_if if3 ();

  assign if0.cpu_ce_i   = ce && (sel == 0);
  assign if0.flush_i    = flush && (sel == 0);
  assign if0.bus_ack_i  = ack && (sel == 0);
  assign if0.cpu_addr_i = addr;
  assign if0.bus_data_i = data_in;
  assign if4.cpu_ce_i   = ce && (sel == 1);
  assign if4.flush_i    = flush && (sel == 1);
  assign if4.bus_ack_i  = ack && (sel == 1);
  assign if4.cpu_addr_i = addr;
  assign if4.bus_data_i = data_in;
  assign if3.cpu_ce_i   = ce && (sel == 2);
  assign if3.flush_i    = flush && (sel == 2);
  assign if3.bus_ack_i  = ack && (sel == 2);
  assign if3.cpu_addr_i = addr;
  assign if3.bus_data_i = data_in;

  inst_bus_if u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  inst_bus_if #(.TIMEOUT_CYC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  inst_bus_if #(.TIMEOUT_CYC(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  logic        m_req, m_stall, m_err;
  logic [31:0] m_data, m_addr;

  always_comb begin
    case (sel)
      1: begin
        m_req = if4.bus_req_o; m_stall = if4.stallreq_o; m_err = if4.err_o;
        m_data = if4.cpu_data_o; m_addr = if4.bus_addr_o;
      end
      2: begin
        m_req = if3.bus_req_o; m_stall = if3.stallreq_o; m_err = if3.err_o;
        m_data = if3.cpu_data_o; m_addr = if3.bus_addr_o;
      end
      default: begin
        m_req = if0.bus_req_o; m_stall = if0.stallreq_o; m_err = if0.err_o;
        m_data = if0.cpu_data_o; m_addr = if0.bus_addr_o;
      end
    endcase
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_req = 1'b0;
  int   busy_n = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // completion = the sample after bus_req_o falls (DONE, or IDLE after a flush)
  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
      busy_n   = 0;
    end else begin
      if (m_req) begin
        busy_n++;
      end else if (prev_req) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_completion: got data %h with no fetch queued", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_data", m_data, mon_e.data);
          check("done_stall", 32'(m_stall), 32'h0);
          check("done_err", 32'(m_err), 32'(mon_e.err));
          check("busy_cycles", 32'(busy_n), 32'(mon_e.busy));
        end
        busy_n = 0;
      end
      prev_req = m_req;
    end
  end

  // Called just after a clock edge with the selected instance in IDLE; returns in IDLE.
  task automatic fetch(input int d, input logic [31:0] a, input int wait_cyc,
                       input logic [31:0] dat, input int flush_cyc, input bit flush_done,
                       input logic [31:0] exp_data, input logic exp_err, input int exp_busy,
                       output int start);
    exp_t e;
    sel   = d;
    ce    = 1'b1;
    addr  = a;
    start = cyc;
    e.data = exp_data;
    e.err  = exp_err;
    e.busy = exp_busy;
    exp_q.push_back(e);
    #1;
    check("stall_idle_req", 32'(m_stall), 32'h1);
    @(posedge clk); #1;
    ce   = 1'b0;
    addr = 32'hBAD0_0000;
    check("req_issued", 32'(m_req), 32'h1);
    check("bus_addr", m_addr, a);
    check("stall_busy", 32'(m_stall), 32'h1);
    for (int k = 0; k < 300; k++) begin
      ack     = (k == wait_cyc);
      data_in = (k == wait_cyc) ? dat : 32'h5A5A_5A5A;
      flush   = (k == flush_cyc);
      @(posedge clk); #1;
      if (!m_req) break;
    end
    ack   = 1'b0;
    flush = flush_done;
    if (m_req) check("req_wait_bound", 32'(m_req), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  int s0, s1, s2;

  initial begin
    rst = 1'b0; ce = 1'b1; flush = 1'b0; ack = 1'b0;
    addr = 32'h1234_5678; data_in = 32'h0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(m_req), 32'h0);
    check("rst_addr", m_addr, 32'h0);
    check("rst_err", 32'(m_err), 32'h0);
    check("rst_stall", 32'(m_stall), 32'h0);
    check("rst_data", m_data, 32'h0);
    #1 rst = 1'b1; ce = 1'b0;
    @(posedge clk); #1;

    // single fetch, ack in the second BUSY cycle
    fetch(0, 32'h4, 1, 32'h3401_1100, -1, 1'b0, 32'h3401_1100, 1'b0, 2, s0);
    check("data_one_cycle", m_data, 32'h0);

    // zero-wait back-to-back fetches
    fetch(0, 32'h0, 0, 32'hAAAA_0001, -1, 1'b0, 32'hAAAA_0001, 1'b0, 1, s0);
    fetch(0, 32'h4, 0, 32'hAAAA_0002, -1, 1'b0, 32'hAAAA_0002, 1'b0, 1, s1);
    fetch(0, 32'h8, 0, 32'hAAAA_0003, -1, 1'b0, 32'hAAAA_0003, 1'b0, 1, s2);
    check("b2b_period_1", 32'(s1 - s0), 32'd3);
    check("b2b_period_2", 32'(s2 - s1), 32'd3);

    // long wait well inside the default timeout
    fetch(0, 32'h100, 20, 32'hCAFE_F00D, -1, 1'b0, 32'hCAFE_F00D, 1'b0, 21, s0);

    // flush one cycle before ack: result discarded, no DONE
    fetch(0, 32'h200, 1, 32'hFFFF_FFFF, 0, 1'b0, 32'h0, 1'b0, 2, s0);
    check("flush_no_leak", m_data, 32'h0);

    // flush during DONE zeroes the delivered word
    fetch(0, 32'h300, 0, 32'h1111_1111, -1, 1'b1, 32'h0, 1'b0, 1, s0);

    // flush in IDLE blocks a new request
    ce = 1'b1; flush = 1'b1; addr = 32'h400;
    #1 check("idle_flush_stall", 32'(m_stall), 32'h0);
    @(posedge clk); #1;
    check("idle_flush_noreq", 32'(m_req), 32'h0);
    ce = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset mid-BUSY, then a late ack while IDLE
    sel = 0; ce = 1'b1; addr = 32'h40;
    @(posedge clk); #1;
    ce = 1'b0;
    check("pre_rst_req", 32'(m_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", 32'(m_req), 32'h0);
    check("async_rst_addr", m_addr, 32'h0);
    check("async_rst_stall", 32'(m_stall), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1; data_in = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      check("late_ack_req", 32'(m_req), 32'h0);
      check("late_ack_data", m_data, 32'h0);
      check("late_ack_stall", 32'(m_stall), 32'h0);
    end
    ack = 1'b0;
    @(posedge clk); #1;

    // timeout with TIMEOUT_CYC=4, then a normal fetch keeps err sticky
    fetch(1, 32'h500, -1, 32'h0, -1, 1'b0, 32'h0, 1'b1, 4, s0);
    check("err_sticky_idle", 32'(m_err), 32'h1);
    fetch(1, 32'h504, 0, 32'h0000_1234, -1, 1'b0, 32'h0000_1234, 1'b1, 1, s0);

    // ack coincides with timeout (TIMEOUT_CYC=3): ack wins
    fetch(2, 32'h600, 2, 32'h0000_0020, -1, 1'b0, 32'h0000_0020, 1'b0, 3, s0);
    check("collision_err", 32'(m_err), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
